// File: rtl/stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_sequencer: round-robin enable/done sequencer with skip mask,       |
// | run/step modes, per-stage watchdog and frame counter.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 200,
  parameter int FRAME_W    = 16
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_i,
  input  logic                                                 run_i,
  input  logic                                                 step_i,
  input  logic [NUM_STAGES-1:0]                                stage_mask_i,
  input  logic [NUM_STAGES-1:0]                                done_i,
  output logic [NUM_STAGES-1:0]                                en_o,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] stage_o,
  output logic                                                 busy_o,
  output logic [FRAME_W-1:0]                                   frame_cnt_o,
  output logic                                                 frame_done_o,
  output logic                                                 timeout_o,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] timeout_stage_o
);

  localparam int c_idx_w = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  // The cursor must be able to hold NUM_STAGES itself, the end-of-frame marker.
  localparam int c_cur_w = $clog2(NUM_STAGES + 1);
  localparam int c_tmr_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cur_w-1:0] c_cur_end  = c_cur_w'(NUM_STAGES);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SELECT    = 2'd1,
    S_WAIT      = 2'd2,
    S_FRAME_END = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cur_w-1:0]   r_cur;
  logic [c_tmr_w-1:0]   r_timer;
  logic                 r_single;

  logic [c_idx_w-1:0]    w_idx;
  logic [NUM_STAGES-1:0] w_grant;

  assign w_idx   = r_cur[c_idx_w-1:0];
  assign w_grant = NUM_STAGES'(1) << w_idx;
  assign busy_o  = (r_state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_cur           <= '0;
      r_timer         <= '0;
      r_single        <= 1'b0;
      en_o            <= '0;
      stage_o         <= '0;
      frame_cnt_o     <= '0;
      frame_done_o    <= 1'b0;
      timeout_o       <= 1'b0;
      timeout_stage_o <= '0;
    end else begin
      frame_done_o <= 1'b0;
      timeout_o    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run_i || step_i) begin
            r_cur    <= '0;
            r_single <= ~run_i;
            r_state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_cur == c_cur_end) begin
            r_state <= S_FRAME_END;
          end else if (stage_mask_i[w_idx]) begin
            en_o    <= w_grant;
            stage_o <= w_idx;
            r_timer <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cur <= r_cur + 1'b1;
          end
        end
        S_WAIT: begin
          // Done is checked first so it beats a watchdog expiry on the same cycle.
          if (done_i[w_idx]) begin
            en_o    <= '0;
            r_cur   <= r_cur + 1'b1;
            r_state <= S_SELECT;
          end else if ((TIMEOUT != 0) && (r_timer == c_tmr_last)) begin
            en_o            <= '0;
            timeout_o       <= 1'b1;
            timeout_stage_o <= w_idx;
            r_cur           <= r_cur + 1'b1;
            r_state         <= S_SELECT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_FRAME_END: begin
          frame_done_o <= 1'b1;
          frame_cnt_o  <= frame_cnt_o + 1'b1;
          if (run_i && !r_single) begin
            r_cur   <= '0;
            r_state <= S_SELECT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stage_sequencer: directed and randomized frames against a frame-level |
// | model (grant order/durations, timeouts, frame period).  Rev 1.0          |
// +--------------------------------------------------------------------------+
module tb_stage_sequencer;

  localparam int N  = 3;
  localparam int T  = 5;
  localparam int FW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, run_i, step_i;
  logic [N-1:0]  stage_mask_i, done_i;
  logic [N-1:0]  en_o;
  logic [1:0]    stage_o, timeout_stage_o;
  logic          busy_o, frame_done_o, timeout_o;
  logic [FW-1:0] frame_cnt_o;

  stage_sequencer #(.NUM_STAGES(N), .TIMEOUT(T), .FRAME_W(FW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .step_i(step_i),
    .stage_mask_i(stage_mask_i), .done_i(done_i), .en_o(en_o),
    .stage_o(stage_o), .busy_o(busy_o), .frame_cnt_o(frame_cnt_o),
    .frame_done_o(frame_done_o), .timeout_o(timeout_o),
    .timeout_stage_o(timeout_stage_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0, cyc = 0;
  int dur_cfg [N];   // cycles each stage takes to answer once enabled
  int hold [N];
  int obs_sig, obs_to, last_k, low_run, ref_cyc, model_frames;
  bit ref_valid, model_single, rand_mode, expect_quiet;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dur_of(input int k);
    return (dur_cfg[k] < T) ? dur_cfg[k] : T;
  endfunction

  // Grant signature: active stages in index order, each with its expected hold time.
  function automatic int exp_sig();
    int s = 0;
    for (int k = 0; k < N; k++) if (stage_mask_i[k]) s = s * 64 + k * 8 + dur_of(k);
    return s;
  endfunction

  function automatic int exp_timeouts();
    int c = 0;
    for (int k = 0; k < N; k++) if (stage_mask_i[k] && dur_cfg[k] > T) c++;
    return c;
  endfunction

  // Frame length: N+1 index visits, one end cycle, plus every granted hold.
  function automatic int exp_period();
    int p = N + 2;
    for (int k = 0; k < N; k++) if (stage_mask_i[k]) p += dur_of(k);
    return p;
  endfunction

  task automatic tick();
    int ended_k;
    @(posedge clk_i);
    #1;
    cyc++;
    ended_k = -1;
    if (rst_i) begin
      for (int k = 0; k < N; k++) hold[k] = 0;
      obs_sig = 0; obs_to = 0; last_k = -1; low_run = 0;
      ref_valid = 0; model_frames = 0; model_single = !run_i;
      done_i = '0;
    end else begin
      chk("en_onehot0", 32'($onehot0(en_o)), 1);
      if (en_o != '0) begin
        chk("busy_while_en", 32'(busy_o), 1);
        chk("stage_matches_en", 32'(en_o), 32'(1) << stage_o);
      end
      if (expect_quiet) chk("en_quiet", 32'(en_o), 0);
      for (int k = 0; k < N; k++) begin
        if (en_o[k]) begin
          if (hold[k] == 0 && last_k >= 0) chk("select_gap", low_run, k - last_k);
          hold[k]++;
        end else if (hold[k] > 0) begin
          obs_sig = obs_sig * 64 + k * 8 + hold[k];
          ended_k = k;
          last_k  = k;
          hold[k] = 0;
        end
      end
      low_run = (en_o == '0) ? low_run + 1 : 0;
      if (timeout_o) begin
        obs_to++;
        chk("timeout_stage", 32'(timeout_stage_o), ended_k);
        if (ended_k >= 0) chk("timeout_long_stage", 32'(dur_cfg[ended_k] > T), 1);
      end
      if (frame_done_o) begin
        model_frames++;
        chk("frame_cnt", 32'(frame_cnt_o), model_frames % 4);
        chk("frame_grants", obs_sig, exp_sig());
        chk("frame_timeouts", obs_to, exp_timeouts());
        if (ref_valid) chk("frame_period", cyc - ref_cyc, exp_period());
        obs_sig = 0; obs_to = 0; last_k = -1;
        if (rand_mode) begin
          stage_mask_i = 3'($urandom_range(0, 7));
          for (int k = 0; k < N; k++) dur_cfg[k] = $urandom_range(1, 7);
        end
        ref_valid = run_i && !model_single;
        ref_cyc   = cyc;
      end
      // Stage responder; non-granted done bits are noise the sequencer must ignore.
      for (int k = 0; k < N; k++)
        done_i[k] = en_o[k] ? (hold[k] >= dur_cfg[k]) : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_idle(input bit use_step);
    ref_cyc = cyc + 1; ref_valid = 1; model_single = use_step;
    if (use_step) step_i = 1'b1; else run_i = 1'b1;
    tick();
    step_i = 1'b0;
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_done_o) return;
    end
    chk("wait_frame_done_expired", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!busy_o) return;
    end
    chk("wait_idle_expired", 0, 1);
  endtask

  task automatic set_dur(input int d0, input int d1, input int d2);
    dur_cfg[0] = d0; dur_cfg[1] = d1; dur_cfg[2] = d2;
  endtask

  initial begin
    int base;
    int cnt_seq [5];
    bit found;
    cnt_seq = '{1, 2, 3, 0, 1};
    rst_i = 1'b1; run_i = 1'b0; step_i = 1'b0; stage_mask_i = '0; done_i = '0;
    set_dur(1, 1, 1);
    for (int k = 0; k < N; k++) hold[k] = 0;
    rand_mode = 0; expect_quiet = 0;
    repeat (2) tick();
    chk("rst_en", 32'(en_o), 0);
    chk("rst_stage", 32'(stage_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_frame_cnt", 32'(frame_cnt_o), 0);
    chk("rst_frame_done", 32'(frame_done_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_timeout_stage", 32'(timeout_stage_o), 0);
    rst_i = 1'b0;
    tick();
    chk("idle_stays_idle", 32'(busy_o), 0);

    // All stages active, 3-cycle holds, back-to-back frames.
    stage_mask_i = 3'b111; set_dur(3, 3, 3);
    start_idle(0);
    for (int i = 1; i <= 3; i++) begin
      wait_fd();
      chk("t1_frame_cnt", 32'(frame_cnt_o), i);
    end
    // Skip the middle stage.
    stage_mask_i = 3'b101;
    repeat (2) wait_fd();
    // Stage 1 never answers: watchdog fires, frame still completes.
    stage_mask_i = 3'b111; set_dur(3, 50, 2);
    repeat (2) wait_fd();
    chk("t3_timeout_stage_held", 32'(timeout_stage_o), 1);
    // Done on the last watchdog cycle wins; 1-cycle minimum grants.
    set_dur(1, 5, 1);
    wait_fd();
    run_i = 1'b0;
    wait_idle();
    chk("run_drop_en", 32'(en_o), 0);

    // Single-step frames; a step while busy is ignored.
    base = model_frames;
    stage_mask_i = 3'b011; set_dur(2, 2, 2);
    start_idle(1);
    wait_fd();
    repeat (3) tick();
    chk("step_busy_after", 32'(busy_o), 0);
    chk("step_en_after", 32'(en_o), 0);
    chk("step_one_frame", 32'(frame_cnt_o), (base + 1) % 4);
    start_idle(1);
    repeat (3) tick();
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    wait_fd();
    repeat (10) tick();
    chk("step_ignored_busy", 32'(frame_cnt_o), (base + 2) % 4);
    chk("step_idle_again", 32'(busy_o), 0);

    // Reset in the middle of stage 1's grant.
    stage_mask_i = 3'b111; set_dur(7, 7, 7);
    start_idle(0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (en_o == 3'b010) found = 1; else tick();
    end
    chk("reach_stage1_grant", 32'(found), 1);
    rst_i = 1'b1;
    tick();
    chk("midrst_en", 32'(en_o), 0);
    chk("midrst_frame_cnt", 32'(frame_cnt_o), 0);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_no_pulse", 32'({frame_done_o, timeout_o}), 0);
    rst_i = 1'b0;
    tick();
    chk("postrst_en_edge1", 32'(en_o), 0);
    tick();
    chk("postrst_en_edge2", 32'(en_o), 3'b001);
    rst_i = 1'b1; run_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();

    // Empty mask: frames still run and counter wraps at 2 bits.
    stage_mask_i = 3'b000; expect_quiet = 1;
    start_idle(0);
    for (int i = 0; i < 5; i++) begin
      wait_fd();
      chk("empty_frame_cnt", 32'(frame_cnt_o), cnt_seq[i]);
    end
    expect_quiet = 0;

    // Random masks and stage latencies, reconfigured at each frame boundary.
    rand_mode = 1;
    repeat (25) wait_fd();
    run_i = 1'b0;
    wait_idle();
    rand_mode = 0;
    chk("final_idle_en", 32'(en_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
